// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/response bundle between the control unit and
// the multi-cycle shifter.
//   start   : request, sampled only while the shifter is idle
//   op      : 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   operand : value to shift, captured on accept
//   shamt   : shift amount 0..31, captured on accept
//   busy    : high whenever the shifter is not idle
//   done    : one-cycle completion pulse; result valid while high
//   result  : registered result, held until the next done
// master = control unit side, slave = shifter side.
interface shift_sequencer_if #(
    parameter int unsigned Width = 32
);
    logic             start;
    logic [1:0]       op;
    logic [Width-1:0] operand;
    logic [4:0]       shamt;
    logic             busy;
    logic             done;
    logic [Width-1:0] result;

    modport master (
        output start, op, operand, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA unit built from a shift-by-2 step
// plus at most one shift-by-1 step.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any operation in flight
//   bus   : shift_sequencer_if.slave (start/op/operand/shamt in,
//           busy/done/result out)
// Latency from the accepting edge N to the done pulse is
// L = floor(s/2) + (s mod 2) + 1 (s forced to 0 for pass-through).
module shift_sequencer #(
    parameter int unsigned Width = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_sequencer_if.slave    bus
);

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpSrl  = 2'b01;
    localparam logic [1:0] OpSra  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    // StLoad is the first busy cycle after accept: it dispatches on the
    // latched count, which is what makes L one more than the step count.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift2,
        StShift1,
        StDone
    } state_e;

    state_e           state_q;
    logic [Width-1:0] work_q;
    logic [1:0]       op_q;
    logic [3:0]       cnt_q;
    logic             odd_q;
    logic             busy_q;
    logic             done_q;
    logic [Width-1:0] result_q;

    logic [Width-1:0] sh1;
    logic [Width-1:0] sh2;

    // One-step shift results; SRA fill replicates the current bit 31, which
    // still equals the original sign because every step preserves it.
    always_comb begin
        sh1 = work_q;
        sh2 = work_q;
        case (op_q)
            OpSll: begin
                sh1 = {work_q[Width-2:0], 1'b0};
                sh2 = {work_q[Width-3:0], 2'b00};
            end
            OpSrl: begin
                sh1 = {1'b0, work_q[Width-1:1]};
                sh2 = {2'b00, work_q[Width-1:2]};
            end
            OpSra: begin
                sh1 = {work_q[Width-1], work_q[Width-1:1]};
                sh2 = {{2{work_q[Width-1]}}, work_q[Width-1:2]};
            end
            default: begin
                sh1 = work_q;
                sh2 = work_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            work_q   <= '0;
            op_q     <= OpSll;
            cnt_q    <= '0;
            odd_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        work_q <= bus.operand;
                        op_q   <= bus.op;
                        if (bus.op == OpPass) begin
                            cnt_q <= '0;
                            odd_q <= 1'b0;
                        end else begin
                            cnt_q <= bus.shamt[4:1];
                            odd_q <= bus.shamt[0];
                        end
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (cnt_q != 4'd0) begin
                        state_q <= StShift2;
                    end else if (odd_q) begin
                        state_q <= StShift1;
                    end else begin
                        state_q  <= StDone;
                        result_q <= work_q;
                        done_q   <= 1'b1;
                    end
                end
                StShift2: begin
                    work_q <= sh2;
                    cnt_q  <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (odd_q) begin
                            state_q <= StShift1;
                        end else begin
                            state_q  <= StDone;
                            result_q <= sh2;
                            done_q   <= 1'b1;
                        end
                    end
                end
                StShift1: begin
                    work_q   <= sh1;
                    state_q  <= StDone;
                    result_q <= sh1;
                    done_q   <= 1'b1;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: expected results and done cycles
// are queued on accept, and a negedge monitor pops and compares on done.
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_sequencer_if #(.Width(32)) bus ();

    shift_sequencer #(.Width(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_n = -1000;
    int          cur_l = 0;
    logic [31:0] last_res = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [1:0] op,
                                               input logic [4:0] s);
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $signed(a) >>> s;
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [4:0] s);
        int n;
        n = (op == 2'b11) ? 0 : int'(s);
        return n / 2 + n % 2 + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy window, done/result against the scoreboard, result hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("busy", 32'(bus.busy), 32'((cyc >= cur_n) && (cyc <= cur_n + cur_l)));
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)",
                                 cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("result", bus.result, mon_e.res);
                        check("done_cycle", 32'(cyc), 32'(mon_e.at));
                        last_res = mon_e.res;
                    end
                end else begin
                    check("result_hold", bus.result, last_res);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [1:0] op, input logic [4:0] s);
        exp_t e;
        int   l;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = a;
        bus.op      = op;
        bus.shamt   = s;
        @(posedge clk);
        #1;
        l     = ref_lat(op, s);
        e.res = ref_result(a, op, s);
        e.at  = cyc + l;
        sb.push_back(e);
        cur_n = cyc;
        cur_l = l;
        // Inputs may change freely once accepted.
        bus.start   = 1'b0;
        bus.operand = $urandom;
        bus.op      = 2'($urandom_range(0, 3));
        bus.shamt   = 5'($urandom_range(0, 31));
    endtask

    // junk: 0 quiet, 1 random start pulses, 2 all-ones start every cycle.
    task automatic run_op(input logic [31:0] a, input logic [1:0] op, input logic [4:0] s,
                          input int junk);
        int l;
        issue(a, op, s);
        l = ref_lat(op, s);
        for (int i = 0; i <= l; i++) begin
            @(negedge clk);
            case (junk)
                1: begin
                    bus.start   = 1'($urandom_range(0, 1));
                    bus.operand = $urandom;
                    bus.op      = 2'($urandom_range(0, 3));
                    bus.shamt   = 5'($urandom_range(0, 31));
                end
                2: begin
                    bus.start   = 1'b1;
                    bus.operand = 32'hFFFF_FFFF;
                    bus.op      = 2'b00;
                    bus.shamt   = 5'd0;
                end
                default: bus.start = 1'b0;
            endcase
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear with no clock edge.
    task automatic async_reset();
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        sb.delete();
        cur_n    = -1000;
        cur_l    = 0;
        last_res = 32'h0;
        rst_n    = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_result", bus.result, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.operand = 32'h0;
        bus.shamt   = 5'd0;
        rst_n       = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("init_busy", 32'(bus.busy), 32'h0);
        check("init_done", 32'(bus.done), 32'h0);
        check("init_result", bus.result, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        run_op(32'h0000_0001, 2'b00, 5'd5, 0);
        idle(1);
        run_op(32'h8000_0000, 2'b10, 5'd31, 0);
        run_op(32'h8000_0000, 2'b01, 5'd31, 1);
        idle(2);
        run_op(32'hDEAD_BEEF, 2'b00, 5'd0, 0);
        run_op(32'hDEAD_BEEF, 2'b11, 5'd17, 1);
        idle(1);
        // Start pulses during SHIFT2 and DONE are ignored; next accept at N+L+2.
        run_op(32'h0000_0003, 2'b00, 5'd2, 2);
        run_op(32'h1234_5678, 2'b01, 5'd4, 0);
        idle(1);

        // Reset four cycles into a long SRL: no done may follow.
        issue(32'hF000_0000, 2'b01, 5'd20);
        repeat (3) @(posedge clk);
        async_reset();
        idle(1);
        run_op(32'hF000_0000, 2'b01, 5'd4, 0);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            run_op($urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1);
            idle($urandom_range(0, 2));
        end
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_done: got %0d outstanding expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
